// File: rtl/cpu_bus_master_if.sv
// CPU configuration bus shared with the cell-rewriting/forwarding table peripheral.
// Data lanes carry one CellCfgType word, DATA_W bits wide.
interface CpuInterface #(
  parameter int DATA_W = 16
);
  logic              busmode;
  logic [11:0]       addr;
  logic              sel;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] dataout;
  logic              rd_DS;
  logic              wr_RW;
  logic              rdy_Dtack;

  modport Test (
    output busmode, addr, sel, datain, rd_DS, wr_RW,
    input  dataout, rdy_Dtack
  );

  modport Device (
    input  busmode, addr, sel, datain, rd_DS, wr_RW,
    output dataout, rdy_Dtack
  );
endinterface

// File: rtl/cpu_bus_master.sv
// Round-robin sequencing master for the CPU configuration bus: one full
// Intel- or Motorola-style read/write handshake per grant, with timeout abort.
module cpu_bus_master #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16,
  parameter int DATA_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mode_motorola,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][11:0]       req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             done,
  output logic                           err,
  output logic [DATA_W-1:0]              rdata,
  output logic                           busy,
  CpuInterface.Test                      cpu
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     win, last_grant, pick;
  logic              we_r, mot_r, err_r;
  logic [11:0]       addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r;
  logic [CW-1:0]     cnt;

  logic              grant, capture, cnt_clr, cnt_inc, fin, fin_err;
  logic              ack_act, found;
  logic [IW:0]       cand;

  // Acknowledge polarity follows the mode latched at grant, not the live input.
  assign ack_act = mot_r ? !cpu.rdy_Dtack : cpu.rdy_Dtack;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ))
        cand = cand - (IW+1)'(NUM_REQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    capture = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    fin     = 1'b0;
    fin_err = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant   = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        cnt_clr = 1'b1;
        state_n = STROBE;
      end
      STROBE: begin
        if (ack_act) begin
          capture = !we_r;
          cnt_clr = 1'b1;
          state_n = HOLD;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          state_n = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      HOLD: begin
        if (!ack_act) begin
          fin     = 1'b1;
          state_n = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          state_n = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win        <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      we_r       <= 1'b0;
      mot_r      <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      rdata_r    <= '0;
      err_r      <= 1'b0;
      cnt        <= '0;
    end else begin
      if (grant) begin
        win     <= pick;
        we_r    <= req_we[pick];
        addr_r  <= req_addr[pick];
        wdata_r <= req_wdata[pick];
        mot_r   <= mode_motorola;
      end
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (capture)      rdata_r <= cpu.dataout;
      if (fin)          err_r <= fin_err;
      if (state == DONE) last_grant <= win;
    end
  end

  // Bus strobes decode from registered state only, so they never glitch on ack.
  always_comb begin
    cpu.sel   = 1'b1;
    cpu.rd_DS = 1'b1;
    cpu.wr_RW = 1'b1;
    if (state == SETUP || state == STROBE || state == HOLD) begin
      cpu.sel = 1'b0;
      if (mot_r) cpu.wr_RW = !we_r;
    end
    if (state == STROBE) begin
      if (mot_r || !we_r) cpu.rd_DS = 1'b0;
      else                cpu.wr_RW = 1'b0;
    end
  end

  assign cpu.busmode = mot_r;
  assign cpu.addr    = addr_r;
  assign cpu.datain  = wdata_r;

  always_comb begin
    done = '0;
    if (state == DONE) done[win] = 1'b1;
  end

  assign err   = (state == DONE) && err_r;
  assign rdata = rdata_r;
  assign busy  = (state != IDLE);
endmodule

// File: tb/tb_cpu_bus_master.sv
// Scoreboard bench for cpu_bus_master with a programmable-latency peripheral model.
module tb_cpu_bus_master;
  logic             clk = 1'b0;
  logic             rst;
  logic             mode_motorola;
  logic [1:0]       req, req_we;
  logic [1:0][11:0] req_addr;
  logic [1:0][15:0] req_wdata;
  logic [1:0]       done;
  logic             err, busy;
  logic [15:0]      rdata;

  CpuInterface #(.DATA_W(16)) cpu_if ();

  cpu_bus_master #(.NUM_REQ(2), .TIMEOUT(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .mode_motorola(mode_motorola),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata(rdata), .busy(busy), .cpu(cpu_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int          who;
    logic        err;
    logic        chk_rd;
    logic [15:0] rdata;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        mot;
    int          rd_low;
    int          wr_low;
    int          sel_low;
    int          cyc;
  } exp_t;

  exp_t q[$];

  function automatic exp_t mk(input int who, input logic e, input logic cr, input logic [15:0] rd,
                              input logic [11:0] a, input logic [15:0] wd, input logic mot,
                              input int rl, input int wl, input int sl, input int cy);
    exp_t x;
    x.who = who; x.err = e; x.chk_rd = cr; x.rdata = rd; x.addr = a; x.wdata = wd;
    x.mot = mot; x.rd_low = rl; x.wr_low = wl; x.sel_low = sl; x.cyc = cy;
    return x;
  endfunction

  // Peripheral: ack in the (ack_delay+1)th strobe cycle, held for rel_delay HOLD cycles.
  int   ack_delay = 0;
  int   rel_delay = 0;
  int   scnt = 0, hcnt = 0;
  logic p_strobe, p_ack;
  always @(negedge clk) begin
    p_ack = 1'b0;
    if (cpu_if.sel) begin
      scnt = 0;
      hcnt = 0;
    end else begin
      p_strobe = cpu_if.busmode ? !cpu_if.rd_DS : (!cpu_if.rd_DS || !cpu_if.wr_RW);
      if (p_strobe) begin
        scnt++;
        p_ack = (scnt > ack_delay);
      end else if (scnt > 0) begin
        hcnt++;
        p_ack = (hcnt <= rel_delay);
      end
    end
    cpu_if.rdy_Dtack = cpu_if.busmode ? !p_ack : p_ack;
  end

  // Monitor: per-transfer bus activity counts, compared when done pulses.
  int   sel_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  exp_t me;
  always @(negedge clk) begin
    if (|done) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: done=%b with nothing outstanding (cycle %0d)", done, cyc);
      end else begin
        me = q.pop_front();
        chk("done_vec", 32'(done), 32'(1) << me.who);
        chk("err", 32'(err), 32'(me.err));
        if (me.chk_rd) chk("rdata", 32'(rdata), 32'(me.rdata));
        chk("rd_low_cycles", sel_cnt == 0 ? 32'hFFFF : 32'(rd_cnt), 32'(me.rd_low));
        chk("wr_low_cycles", 32'(wr_cnt), 32'(me.wr_low));
        chk("sel_low_cycles", 32'(sel_cnt), 32'(me.sel_low));
        chk("done_cycle", 32'(cyc), 32'(me.cyc));
      end
      sel_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    end else if (!busy) begin
      sel_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    end else begin
      if (!cpu_if.sel && sel_cnt == 0 && q.size() > 0) begin
        chk("setup_addr", 32'(cpu_if.addr), 32'(q[0].addr));
        chk("setup_datain", 32'(cpu_if.datain), 32'(q[0].wdata));
        chk("setup_busmode", 32'(cpu_if.busmode), 32'(q[0].mot));
      end
      if (!cpu_if.sel)   sel_cnt++;
      if (!cpu_if.rd_DS) rd_cnt++;
      if (!cpu_if.wr_RW) wr_cnt++;
    end
  end

  task automatic issue(input int who, input logic we, input logic [11:0] a, input logic [15:0] wd);
    req_we[who]    = we;
    req_addr[who]  = a;
    req_wdata[who] = wd;
    req[who]       = 1'b1;
  endtask

  task automatic wait_done(input int who);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done[who]) return;
    end
    checks++;
    $display("FAIL wait_done: requester %0d got no done within 100 cycles", who);
  endtask

  task automatic gap();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int c;
  initial begin
    rst = 1'b1; mode_motorola = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    cpu_if.dataout = 16'h0000;
    cpu_if.rdy_Dtack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_sel", 32'(cpu_if.sel), 32'd1);
    chk("rst_rd_DS", 32'(cpu_if.rd_DS), 32'd1);
    chk("rst_wr_RW", 32'(cpu_if.wr_RW), 32'd1);
    chk("rst_busmode", 32'(cpu_if.busmode), 32'd0);
    chk("rst_addr", 32'(cpu_if.addr), 32'd0);
    chk("rst_datain", 32'(cpu_if.datain), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    gap();

    // Intel write, immediate ack, released after one cycle.
    ack_delay = 0; rel_delay = 0;
    c = cyc;
    q.push_back(mk(0, 0, 1, 16'h0000, 12'h005, 16'h1234, 0, 0, 1, 3, c + 4));
    issue(0, 1'b1, 12'h005, 16'h1234);
    wait_done(0); req[0] = 1'b0;
    gap();

    // Motorola read, DTACK after 3 waits; mode input flipped mid-transfer.
    ack_delay = 3; rel_delay = 0;
    cpu_if.dataout = 16'hBEEF;
    mode_motorola = 1'b1;
    c = cyc;
    q.push_back(mk(1, 0, 1, 16'hBEEF, 12'hABC, 16'h7777, 1, 4, 0, 6, c + 7));
    issue(1, 1'b0, 12'hABC, 16'h7777);
    @(negedge clk);
    mode_motorola = 1'b0;
    wait_done(1); req[1] = 1'b0;
    gap();

    // Intel read, no ack: strobe timeout, rdata keeps its previous value.
    ack_delay = 1000; rel_delay = 0;
    cpu_if.dataout = 16'h5555;
    c = cyc;
    q.push_back(mk(0, 1, 1, 16'hBEEF, 12'h0F0, 16'h0000, 0, 16, 0, 17, c + 18));
    issue(0, 1'b0, 12'h0F0, 16'h0000);
    wait_done(0); req[0] = 1'b0;
    gap();

    // Intel write, ack never released: HOLD timeout.
    ack_delay = 0; rel_delay = 1000;
    c = cyc;
    q.push_back(mk(1, 1, 1, 16'hBEEF, 12'h3FF, 16'h00FF, 0, 0, 1, 18, c + 19));
    issue(1, 1'b1, 12'h3FF, 16'h00FF);
    wait_done(1); req[1] = 1'b0;
    gap();

    // Both requesters held: grants alternate 0,1,0,1 with 5-cycle spacing.
    ack_delay = 0; rel_delay = 0;
    cpu_if.dataout = 16'h0A0A;
    c = cyc;
    q.push_back(mk(0, 0, 1, 16'hBEEF, 12'h010, 16'h1111, 0, 0, 1, 3, c + 4));
    q.push_back(mk(1, 0, 1, 16'h0A0A, 12'h020, 16'h2222, 0, 1, 0, 3, c + 9));
    q.push_back(mk(0, 0, 1, 16'h0A0A, 12'h010, 16'h1111, 0, 0, 1, 3, c + 14));
    q.push_back(mk(1, 0, 1, 16'h0A0A, 12'h020, 16'h2222, 0, 1, 0, 3, c + 19));
    issue(0, 1'b1, 12'h010, 16'h1111);
    issue(1, 1'b0, 12'h020, 16'h2222);
    wait_done(0);
    wait_done(1);
    wait_done(0); req[0] = 1'b0;
    wait_done(1); req[1] = 1'b0;
    gap();

    // Plain read by requester 0 so that requester 1 would be next in turn.
    cpu_if.dataout = 16'h3C3C;
    c = cyc;
    q.push_back(mk(0, 0, 1, 16'h3C3C, 12'h444, 16'h0000, 0, 1, 0, 3, c + 4));
    issue(0, 1'b0, 12'h444, 16'h0000);
    wait_done(0); req[0] = 1'b0;
    gap();

    // Reset in the middle of STROBE: transfer dropped, no done, arbiter restarts.
    ack_delay = 1000;
    issue(0, 1'b0, 12'h555, 16'h0000);
    repeat (3) @(negedge clk);
    chk("abort_strobe_active", 32'(cpu_if.rd_DS), 32'd0);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("abort_sel", 32'(cpu_if.sel), 32'd1);
    chk("abort_rd_DS", 32'(cpu_if.rd_DS), 32'd1);
    chk("abort_wr_RW", 32'(cpu_if.wr_RW), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    gap();

    ack_delay = 0;
    cpu_if.dataout = 16'h6006;
    c = cyc;
    q.push_back(mk(0, 0, 1, 16'h6006, 12'h111, 16'h0000, 0, 1, 0, 3, c + 4));
    q.push_back(mk(1, 0, 1, 16'h6006, 12'h222, 16'hCAFE, 0, 0, 1, 3, c + 9));
    issue(0, 1'b0, 12'h111, 16'h0000);
    issue(1, 1'b1, 12'h222, 16'hCAFE);
    wait_done(0); req[0] = 1'b0;
    wait_done(1); req[1] = 1'b0;
    gap();

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cpu_bus_master.md
# cpu_bus_master

Sequencing master for the switch's CPU configuration bus (`CpuInterface`, `Test` modport side), which shares it between `NUM_REQ` internal requesters such as the host bridge and the statistics/scrub engine. It grants one requester at a time with round-robin priority and runs one complete read or write handshake per grant, in either Intel or Motorola bus mode. It captures read data, reports completion, and aborts hung transfers after a timeout. It sits between the configuration requesters and the cell-rewriting/forwarding table peripheral.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8).
- `TIMEOUT`, 16, maximum cycles waited for an acknowledge assertion, or for its release.

- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `mode_motorola`  input  1  bus mode, sampled only in IDLE when a grant is made; 0 = Intel, 1 = Motorola.
- `req`  input  NUM_REQ  per-requester transfer request (level).
- `req_we`  input  NUM_REQ  1 = write, 0 = read.
- `req_addr`  input  NUM_REQ x 12  word address per requester.
- `req_wdata`  input  NUM_REQ x CellCfgType  write data per requester.
- `done`  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- `err`  output  1  valid with `done`; 1 = timeout abort.
- `rdata`  output  CellCfgType  read data; valid with `done` for reads.
- `busy`  output  1  high in every state except IDLE.
- `cpu`  interface  CpuInterface.Test  bus master port; drives `busmode`, `addr`, `sel`, `datain`, `rd_DS`, `wr_RW`; samples `dataout`, `rdy_Dtack`.

## Operation
- Bus signal polarities:
  - `sel`: active-low chip select.
  - Intel (`busmode`=0): `rd_DS` is the active-low read strobe; `wr_RW` is the active-low write strobe; `rdy_Dtack` is active-high ready.
  - Motorola (`busmode`=1): `rd_DS` is the active-low data strobe; `wr_RW` is 1 for read and 0 for write; `rdy_Dtack` is active-low DTACK.
- FSM has five states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - If any `req` bit is set, pick the winner round-robin, starting at `last_grant`+1.
  - Register the winner index, its `req_we`/`req_addr`/`req_wdata`, and `mode_motorola`; go to SETUP.
  - Requesters must hold `req` until `done`. Their other inputs only need to be stable in the grant cycle.
- SETUP, one cycle:
  - `sel`=0; `addr`, `busmode` and `datain` driven (`datain` driven for writes and reads alike).
  - Motorola: `wr_RW` carries direction.
  - Strobes stay inactive. Go to STROBE and clear the timeout counter.
- STROBE:
  - Assert the strobe: Intel `rd_DS`=0 (read) or `wr_RW`=0 (write); Motorola `rd_DS`=0.
  - Ack active at a clock edge: for reads, capture `dataout` into `rdata`; go to HOLD and clear the counter.
  - Otherwise increment the counter. On reaching TIMEOUT, go to DONE with err=1.
- HOLD:
  - Strobe inactive, `sel` still 0, `addr`/`datain` held.
  - Ack inactive at a clock edge: go to DONE with err=0.
  - Otherwise count. On reaching TIMEOUT, go to DONE with err=1.
- DONE, one cycle:
  - `sel`=1, strobes inactive.
  - `done[winner]`=1 and `err` valid; `last_grant` updated to the winner. Go to IDLE.
- `rdata` keeps its last captured value; it is unchanged by writes and by aborted reads.
- `addr`/`datain`/`busmode` hold their last values while idle.
- A `req` withdrawn before grant is ignored. Withdrawal after grant is illegal, and the transfer completes anyway.

## Timing
- Reset values:
  - `sel`=1, `rd_DS`=1, `wr_RW`=1, `busmode`=0.
  - `addr`=0, `datain`=0, `rdata`=0.
  - `done`=0, `err`=0, `busy`=0.
  - state IDLE; `last_grant`=NUM_REQ-1, so requester 0 wins first.
- Cycle numbering for a request sampled at end of cycle 0:
  - SETUP is cycle 1 and strobe asserts in cycle 2.
  - With ack seen at end of cycle 2 and released by end of cycle 3, `done` pulses in cycle 4.
  - Minimum latency from request to `done` is 4 cycles.
- After DONE, IDLE lasts one cycle, so the next SETUP at the earliest is 2 cycles after `done`. `sel` is high for 2 cycles between back-to-back transfers.
- Ack is sampled only at clock edges. No combinational path exists from bus inputs to outputs.
- Timeout: the strobe is active for exactly TIMEOUT cycles (cycles 2..TIMEOUT+1), then DONE.
- `mode_motorola` changes mid-transfer are ignored until the next grant.
- A `rst` asserted in any state returns all outputs to reset values at the next edge with no `done` pulse, and the transfer is discarded.

## Test plan
- Intel write, req0 with addr=0x005 and wdata=W; peripheral acks in the first STROBE cycle and releases after 1 cycle → `wr_RW` low exactly 1 cycle, `sel` low cycles 1–3, `done[0]` in cycle 4, err=0, `rd_DS` never low.
- Motorola read of addr=0xABC with `dataout`=D and DTACK delayed 3 cycles → `wr_RW`=1 and `rd_DS` low 4 cycles, `rdata`=D at `done`, err=0.
- `req`=2'b11 held continuously → grants go 0,1,0,1; each `done` goes only to its winner; `sel` is high 2 cycles between transfers.
- No ack, TIMEOUT=16 → strobe low cycles 2–17, DONE in cycle 18 with err=1, `rdata` unchanged; next request serviced normally.
- Ack never released after assertion → HOLD aborts after 16 cycles with err=1.
- `rst` pulsed during STROBE → next cycle `sel`=1, `rd_DS`=1, `wr_RW`=1, `busy`=0, no `done`; the following request goes to requester 0.
